// File: rtl/acq_pkg.sv
// Shared constants and helpers for the acquisition ring buffer.
// Holds the output lane width, the lane-packing rule and parameter-legality checks.
package acq_pkg;

  localparam int LANE_W = 16;

  // Zero-extended sample in, lane out; left-justify moves the MSB to bit 15.
  function automatic logic [LANE_W-1:0] pack_lane(input logic [LANE_W-1:0] s,
                                                  input int sample_w, input bit left);
    if (left) return s << (LANE_W - sample_w);
    return s;
  endfunction

  function automatic bit params_ok(input int sample_w, input int num_ch, input int addr_w);
    return (sample_w >= 1) && (sample_w <= LANE_W) &&
           (num_ch >= 1) && (num_ch <= 8) &&
           (addr_w >= 1) && (addr_w <= 16);
  endfunction

endpackage

// File: rtl/acq_ring_buffer_if.sv
// Sample-in / frame-out bus of the acquisition ring buffer.
interface acq_ring_buffer_if #(
  parameter int SAMPLE_W = 12,
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 5
);
  import acq_pkg::*;

  logic                       acq_en;
  logic                       wr_valid;
  logic [SAMPLE_W-1:0]        wr_data;
  logic                       rd_req;
  logic                       rd_valid;
  logic [LANE_W*NUM_CH-1:0]   rd_data;
  logic [ADDR_W:0]            level;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output acq_en, wr_valid, wr_data, rd_req,
    input  rd_valid, rd_data, level, empty, full, overflow, underflow
  );

  modport slave (
    input  acq_en, wr_valid, wr_data, rd_req,
    output rd_valid, rd_data, level, empty, full, overflow, underflow
  );
endinterface

// File: rtl/acq_frame_ram.sv
// Simple dual-port frame store, read-first, one-cycle registered read (BRAM style).
module acq_frame_ram #(
  parameter int W  = 36,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**AW];

  // Read returns the old word on a same-address write, which the full+pop case relies on.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/acq_ring_buffer.sv
// Frame-assembling ring buffer: interleaved ADC samples in, packed 16-bit-lane frames out.
// Pointers, level, sticky flags and the output register stage live here; storage is acq_frame_ram.
module acq_ring_buffer
  import acq_pkg::*;
#(
  parameter int SAMPLE_W     = 12,
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 5,
  parameter bit LEFT_JUSTIFY = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  acq_ring_buffer_if.slave bus
);
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              FRAME_W = SAMPLE_W * NUM_CH;
  localparam int              STAGES  = 2;
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

  if (!params_ok(SAMPLE_W, NUM_CH, ADDR_W)) begin : g_bad_params
    $error("acq_ring_buffer: illegal SAMPLE_W/NUM_CH/ADDR_W");
  end

  // Assert asynchronously, release two clocks after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       srst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign srst_n = rst_sync_q[1];

  logic [CH_W-1:0]                     ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     asm_q, asm_d, frame_w, ram_rdata;
  logic [ADDR_W-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]                     level_q, level_d;
  logic                                empty_q, empty_d, full_q, full_d;
  logic                                ovf_q, ovf_d, unf_q, unf_d;
  logic [STAGES:0]                     vld_pipe;
  logic [NUM_CH-1:0][LANE_W-1:0]       lanes, rd_data_q;
  logic                                commit, pop, push;

  always_comb begin
    commit  = bus.acq_en && bus.wr_valid && (ch_idx_q == CH_W'(NUM_CH-1));
    pop     = bus.acq_en && bus.rd_req && !empty_q;
    push    = commit && (!full_q || pop);
    frame_w = asm_q;
    frame_w[NUM_CH-1] = bus.wr_data;
  end

  always_comb begin
    ch_idx_d = ch_idx_q;
    asm_d    = asm_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (!bus.acq_en) begin
      ch_idx_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (bus.wr_valid) begin
        asm_d[ch_idx_q] = bus.wr_data;
        ch_idx_d = (ch_idx_q == CH_W'(NUM_CH-1)) ? '0 : ch_idx_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (commit && full_q && !pop) ovf_d = 1'b1;
      if (bus.rd_req && empty_q)    unf_d = 1'b1;
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH);
  end

  assign vld_pipe[0] = pop;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      ch_idx_q  <= '0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
      rd_data_q <= '0;
    end else begin
      ch_idx_q  <= ch_idx_d;
      asm_q     <= asm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      vld_pipe[STAGES:1] <= bus.acq_en ? vld_pipe[STAGES-1:0] : '0;
      if (bus.acq_en && vld_pipe[STAGES-1]) rd_data_q <= lanes;
    end
  end

  acq_frame_ram #(.W(FRAME_W), .AW(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (frame_w),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign lanes[k] = pack_lane(LANE_W'(ram_rdata[k]), SAMPLE_W, LEFT_JUSTIFY);
  end

  assign bus.rd_valid  = vld_pipe[STAGES];
  assign bus.rd_data   = rd_data_q;
  assign bus.level     = level_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_acq_ring_buffer.sv
// Directed bench for acq_ring_buffer: default build plus a left-justified build.
module tb_acq_ring_buffer;
  logic clk = 1'b0;
  logic rst_n, rst_lj_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  acq_ring_buffer_if #(.SAMPLE_W(12), .NUM_CH(3), .ADDR_W(5)) bus ();
  acq_ring_buffer_if #(.SAMPLE_W(12), .NUM_CH(3), .ADDR_W(5)) lj ();

  acq_ring_buffer #(.SAMPLE_W(12), .NUM_CH(3), .ADDR_W(5), .LEFT_JUSTIFY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  acq_ring_buffer #(.SAMPLE_W(12), .NUM_CH(3), .ADDR_W(5), .LEFT_JUSTIFY(1'b1)) u_lj (
    .clk(clk), .rst_n(rst_lj_n), .bus(lj));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic lj_wr(input logic [11:0] d);
    lj.wr_valid = 1'b1;
    lj.wr_data  = d;
    tick();
    lj.wr_valid = 1'b0;
  endtask

  // Frame i carries sample (k<<8)+i on channel k.
  function automatic logic [47:0] frm(input int i);
    return {16'h0200 + 16'(i), 16'h0100 + 16'(i), 16'(i)};
  endfunction

  task automatic wr_frame(input int i);
    for (int k = 0; k < 3; k++) wr(12'((k << 8) + i));
  endtask

  task automatic clear();
    bus.acq_en = 1'b0;
    tick();
    bus.acq_en = 1'b1;
  endtask

  // n back-to-back requests; expects an unbroken stream of frames first..first+n-1.
  task automatic pop_burst(input int first, input int n);
    for (int t = 0; t <= n + 1; t++) begin
      bus.rd_req = (t < n);
      tick();
      if (t >= 1 && t <= n) begin
        check("burst_valid", 64'(bus.rd_valid), 64'd1);
        check("burst_data",  64'(bus.rd_data),  64'(frm(first + t - 1)));
      end
    end
    check("burst_end_valid", 64'(bus.rd_valid), 64'd0);
  endtask

  initial begin
    bus.acq_en = 1'b1; bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    lj.acq_en  = 1'b1; lj.wr_valid  = 1'b0; lj.wr_data  = '0; lj.rd_req  = 1'b0;
    rst_n = 1'b0; rst_lj_n = 1'b0;
    tick(); tick();

    check("rst_valid", 64'(bus.rd_valid),  64'd0);
    check("rst_data",  64'(bus.rd_data),   64'd0);
    check("rst_level", 64'(bus.level),     64'd0);
    check("rst_empty", 64'(bus.empty),     64'd1);
    check("rst_full",  64'(bus.full),      64'd0);
    check("rst_ovf",   64'(bus.overflow),  64'd0);
    check("rst_unf",   64'(bus.underflow), 64'd0);

    rst_n = 1'b1; rst_lj_n = 1'b1;
    tick(); tick(); tick();

    // Basic frame round trip
    wr(12'h123); wr(12'h456); wr(12'h789);
    check("one_level", 64'(bus.level), 64'd1);
    check("one_empty", 64'(bus.empty), 64'd0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("lat_early_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    check("lat_valid", 64'(bus.rd_valid), 64'd1);
    check("lat_data",  64'(bus.rd_data),  64'h0789_0456_0123);
    check("pop_level", 64'(bus.level),    64'd0);
    check("pop_empty", 64'(bus.empty),    64'd1);
    tick();
    check("pulse_valid", 64'(bus.rd_valid), 64'd0);
    check("hold_data",   64'(bus.rd_data),  64'h0789_0456_0123);

    // Underflow
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    check("unf_valid", 64'(bus.rd_valid),  64'd0);
    check("unf_flag",  64'(bus.underflow), 64'd1);
    check("unf_level", 64'(bus.level),     64'd0);
    clear();
    check("clr_unf", 64'(bus.underflow), 64'd0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 32; i++) wr_frame(i);
    check("fill_full",  64'(bus.full),     64'd1);
    check("fill_level", 64'(bus.level),    64'd32);
    check("fill_ovf",   64'(bus.overflow), 64'd0);
    wr_frame(33);
    check("ovf_flag",  64'(bus.overflow), 64'd1);
    check("ovf_level", 64'(bus.level),    64'd32);
    pop_burst(1, 32);
    check("drain_level", 64'(bus.level), 64'd0);
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("ovf_sticky",  64'(bus.overflow), 64'd1);
    clear();
    check("clr_ovf", 64'(bus.overflow), 64'd0);

    // Commit and pop in the same cycle while full
    for (int i = 1; i <= 32; i++) wr_frame(i);
    wr(12'h021); wr(12'h121);
    bus.wr_valid = 1'b1; bus.wr_data = 12'h221; bus.rd_req = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    check("both_level", 64'(bus.level),    64'd32);
    check("both_full",  64'(bus.full),     64'd1);
    check("both_ovf",   64'(bus.overflow), 64'd0);
    tick();
    check("both_valid", 64'(bus.rd_valid), 64'd1);
    check("both_data",  64'(bus.rd_data),  64'(frm(1)));
    pop_burst(2, 32);
    check("wrap_empty", 64'(bus.empty), 64'd1);
    clear();

    // Partial frame discarded by an acq_en pulse
    wr(12'h111); wr(12'h222);
    clear();
    wr(12'hAAA); wr(12'hBBB); wr(12'hCCC);
    check("part_level", 64'(bus.level), 64'd1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    check("part_valid", 64'(bus.rd_valid), 64'd1);
    check("part_data",  64'(bus.rd_data),  64'h0CCC_0BBB_0AAA);

    // Left-justified lanes, then reset mid-read
    lj_wr(12'hABC); lj_wr(12'h001); lj_wr(12'hFFF);
    lj.rd_req = 1'b1;
    tick();
    lj.rd_req = 1'b0;
    tick();
    check("lj_valid", 64'(lj.rd_valid), 64'd1);
    check("lj_data",  64'(lj.rd_data),  64'hFFF0_0010_ABC0);
    lj_wr(12'h123); lj_wr(12'h456); lj_wr(12'h789);
    lj.rd_req = 1'b1;
    tick();
    lj.rd_req = 1'b0;
    rst_lj_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(lj.rd_valid), 64'd0);
    check("mid_rst_data",  64'(lj.rd_data),  64'd0);
    check("mid_rst_level", 64'(lj.level),    64'd0);
    tick();
    check("mid_rst_valid2", 64'(lj.rd_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/acq_ring_buffer.md
ACQ_RING_BUFFER -- requirements
Module: acq_ring_buffer

Interface
REQ-001 Parameter SAMPLE_W, default 12, ADC sample width; legal range 1..16.
REQ-002 Parameter NUM_CH, default 3, channels per frame; legal range 1..8.
REQ-003 Parameter ADDR_W, default 5, log2 of ring depth in frames (depth 32).
REQ-004 Parameter LEFT_JUSTIFY, default 0, lane alignment: 0 = zero-extend MSBs, 1 = left-align and zero-fill LSBs.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 acq_en  input  1  acquisition enable; low = synchronous clear.
REQ-008 wr_valid  input  1  one-cycle strobe qualifying wr_data.
REQ-009 wr_data  input  SAMPLE_W  sample, channel-interleaved ch0..ch(NUM_CH-1).
REQ-010 rd_req  input  1  one-cycle request to pop one frame.
REQ-011 rd_valid  output  1  one-cycle pulse, rd_data holds a popped frame.
REQ-012 rd_data  output  16*NUM_CH  frame; channel k in bits [16k+15:16k].
REQ-013 level  output  ADDR_W+1  committed frames held (0..2^ADDR_W).
REQ-014 empty  output  1  level == 0.
REQ-015 full  output  1  level == 2^ADDR_W.
REQ-016 overflow  output  1  sticky, a completed frame was dropped.
REQ-017 underflow  output  1  sticky, rd_req arrived while empty.

Function
REQ-018 Frame assembler: channel index ch_idx advances on each wr_valid while acq_en=1; wraps NUM_CH-1 -> 0.
REQ-019 On the wr_valid with ch_idx = NUM_CH-1, the frame commits at wr_ptr in the same cycle if not full; wr_ptr += 1 modulo 2^ADDR_W.
REQ-020 Commit while full and rd_req=0: frame dropped, wr_ptr unchanged, overflow set, ch_idx still wraps to 0.
REQ-021 rd_req with empty=0: read rd_ptr, rd_ptr += 1 modulo 2^ADDR_W; rd_valid and rd_data appear exactly 2 cycles after rd_req.
REQ-022 rd_req with empty=1: ignored, no rd_valid, underflow set.
REQ-023 Same-cycle commit and accepted pop: level unchanged; commit while full is accepted when a pop is accepted that cycle.
REQ-024 Back-to-back rd_req every cycle yields rd_valid every cycle (fully pipelined).
REQ-025 Lane packing per LEFT_JUSTIFY; unused lane bits are 0.
REQ-026 rd_data holds its last value when rd_valid=0.
REQ-027 acq_en low: clear ch_idx, pointers, level, overflow, underflow; discard partial frame; kill in-flight rd_valid; ignore wr_valid/rd_req; rd_data holds.
REQ-028 empty, full, level are registered and consistent in the same cycle.

Reset
REQ-029 rst_n low asynchronously forces: rd_valid=0, rd_data=0, level=0, empty=1, full=0, overflow=0, underflow=0, ch_idx=0, both pointers 0.
REQ-030 RAM contents are not reset; no RAM data is observable before a commit.
REQ-031 Release of rst_n is synchronised internally by the block's two-flop reset synchroniser.

Structure
REQ-032 Package acq_pkg holds LANE_W=16, the lane-packing function, and parameter-legality checks.
REQ-033 One sub-module acq_frame_ram: simple dual-port, width SAMPLE_W*NUM_CH, depth 2^ADDR_W, one-cycle registered read, inferable as BRAM.
REQ-034 Pointers, level and flags live in acq_ring_buffer; the output register stage is in acq_ring_buffer.

Verification
REQ-035 Defaults; write 3 samples 0x123, 0x456, 0x789, then rd_req -> rd_valid 2 cycles later, rd_data = 0x0789_0456_0123, level 1 -> 0.
REQ-036 Write 33 frames without reading -> full=1 after frame 32, overflow=1 on frame 33, level=32; 32 pops return frames 1..32 in order.
REQ-037 rd_req on empty -> no rd_valid, underflow=1, level stays 0.
REQ-038 Full ring; commit and rd_req in the same cycle -> level stays 32, no overflow, wr_ptr and rd_ptr both wrap.
REQ-039 Two samples written, acq_en pulsed low 1 cycle, then 3 samples A, B, C -> popped frame is {C, B, A}; partial frame discarded.
REQ-040 LEFT_JUSTIFY=1, SAMPLE_W=12, sample 0xABC -> lane reads 0xABC0; rst_n asserted mid-read -> rd_valid 0 immediately.
